polar_decode: RTL and testbench



---
 rtl/polar_decode.sv | 106 ++++++++++
 tb/tb_polar_decode.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/polar_decode.sv
// Hard-decision polar decoder, N=256 / K=128: iterative inverse transform
// (one butterfly stage per cycle) followed by information-bit extraction.
module polar_decode #(
    parameter int             N         = 256,
    parameter int             K         = 128,
    parameter logic [N-1:0]   INFO_MASK = {{128{1'b1}}, {128{1'b0}}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   data_in,
    input  logic           valid_i,
    output logic           ready_o,
    output logic [K-1:0]   data_out,
    output logic           valid_o,
    output logic           frozen_err_o
);
    localparam int STAGES = 8;

    typedef enum logic {IDLE, XFORM} state_t;

    state_t                        state;
    logic [2:0]                    stage;
    logic [N-1:0]                  work;
    logic [N-1:0]                  next_work;
    logic [STAGES-1:0][N-1:0]      stage_out;
    logic [K-1:0]                  info_bits;
    logic                          frozen_any;

    // Position of the k-th set bit of INFO_MASK, resolved at elaboration.
    function automatic int info_pos(input int k);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (INFO_MASK[i]) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    // All eight butterfly stages are built side by side; the stage counter
    // picks which one lands in the work register this cycle.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (((i >> s) & 1) == 0) begin : g_upper
                assign stage_out[s][i] = work[i] ^ work[i + (1 << s)];
            end else begin : g_lower
                assign stage_out[s][i] = work[i];
            end
        end
    end

    always_comb begin
        next_work = stage_out[stage];
    end

    for (genvar k = 0; k < K; k++) begin : g_extract
        assign info_bits[k] = next_work[info_pos(k)];
    end

    assign frozen_any = |(next_work & ~INFO_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            stage        <= '0;
            work         <= '0;
            ready_o      <= 1'b1;
            valid_o      <= 1'b0;
            data_out     <= '0;
            frozen_err_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        work    <= data_in;
                        stage   <= '0;
                        ready_o <= 1'b0;
                        state   <= XFORM;
                    end
                end
                XFORM: begin
                    work <= next_work;
                    if (stage == 3'd7) begin
                        data_out     <= info_bits;
                        frozen_err_o <= frozen_any;
                        valid_o      <= 1'b1;
                        ready_o      <= 1'b1;
                        stage        <= '0;
                        state        <= IDLE;
                    end else begin
                        stage <= stage + 3'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_polar_decode.sv
// Scoreboard bench for polar_decode: expected info bits and frozen flag are
// computed from an independent subset-XOR model when each frame is accepted.
module tb_polar_decode;
    logic         clk;
    logic         rst;
    logic [255:0] data_in;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] data_out;
    logic         valid_o;
    logic         frozen_err_o;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   last_acc = 0;
    bit   stream_mode = 0;
    int   stream_accs = 0;

    polar_decode dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_out     (data_out),
        .valid_o      (valid_o),
        .frozen_err_o (frozen_err_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // u[j] = XOR of x[i] over every i whose bit-set contains j (self-inverse).
    function automatic logic [255:0] subset_xform(input logic [255:0] x);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 256; j++)
            for (int i = 0; i < 256; i++)
                if ((i & j) == j) r[j] = r[j] ^ x[i];
        return r;
    endfunction

    function automatic logic [255:0] encode(input logic [127:0] d);
        return subset_xform({d, 128'b0});
    endfunction

    // Output check, then acceptance bookkeeping, once per cycle away from the edge.
    always @(negedge clk) begin
        exp_t e;
        logic [255:0] u;
        if (rst) begin
            q.delete();
        end
        if (valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("data_out", data_out, e.data);
                chk("frozen_err", {127'b0, frozen_err_o}, {127'b0, e.err});
                chk("latency", cyc - e.cyc, 9);
            end
        end
        if (valid_i && ready_o && !rst) begin
            u = subset_xform(data_in);
            e.data = u[255:128];
            e.err  = |u[127:0];
            e.cyc  = cyc;
            q.push_back(e);
            if (stream_mode) begin
                if (stream_accs > 0) chk("spacing", cyc - last_acc, 9);
                stream_accs++;
            end
            last_acc = cyc;
            acc_cnt++;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic present(input logic [255:0] x);
        int c0;
        int t;
        c0 = acc_cnt;
        t = 0;
        data_in = x;
        valid_i = 1;
        while (acc_cnt == c0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (acc_cnt == c0) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [127:0] d;

    initial begin
        rst = 1;
        valid_i = 0;
        data_in = '0;
        #2;
        chk("rst_ready", {127'b0, ready_o}, 1);
        chk("rst_valid", {127'b0, valid_o}, 0);
        chk("rst_data", data_out, 0);
        chk("rst_err", {127'b0, frozen_err_o}, 0);
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;

        // all-zero frame, with ready_o low for exactly 8 cycles
        present('0);
        valid_i = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ready_busy", {127'b0, ready_o}, 0);
        end
        @(negedge clk);
        chk("ready_back", {127'b0, ready_o}, 1);
        chk("valid_pulse", {127'b0, valid_o}, 1);
        @(negedge clk);
        chk("valid_one_cycle", {127'b0, valid_o}, 0);
        chk("hold_data", data_out, 0);
        drain();

        // directed patterns with hand-derived results
        present((256'b1 << 128) | 256'b1);
        valid_i = 0;
        drain();
        chk("enc_bit0", data_out, 128'h1);
        chk("enc_bit0_err", {127'b0, frozen_err_o}, 0);

        present(256'b1 << 255);
        valid_i = 0;
        drain();
        chk("top_bit", data_out, {128{1'b1}});
        chk("top_bit_err", {127'b0, frozen_err_o}, 1);

        present(256'b1);
        valid_i = 0;
        drain();
        chk("x0_only", data_out, 0);
        chk("x0_only_err", {127'b0, frozen_err_o}, 1);

        // back-to-back stream with valid_i held high throughout
        stream_mode = 1;
        for (int f = 0; f < 3; f++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            present(encode(d));
        end
        valid_i = 0;
        stream_mode = 0;
        drain();
        chk("stream_count", stream_accs, 3);

        // reset during the transform
        d = {$urandom, $urandom, $urandom, $urandom};
        present(encode(d));
        valid_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("midrst_ready", {127'b0, ready_o}, 1);
        chk("midrst_data", data_out, 0);
        chk("midrst_valid", {127'b0, valid_o}, 0);
        repeat (12) @(posedge clk);
        #1 rst = 0;
        chk("midrst_quiet", data_out, 0);
        @(posedge clk);
        #1;

        d = {$urandom, $urandom, $urandom, $urandom};
        present(encode(d));
        valid_i = 0;
        drain();
        chk("post_rst_frame", data_out, d);
        chk("post_rst_err", {127'b0, frozen_err_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
